// File: rtl/score_display_ctrl.sv
// Score display sequencer: digit-scan tick, session highscore, and the
// highscore_disp selection (button peek and post-game alternation).
module score_display_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int PHASE_CYCLES = 50000000,
  parameter int PEEK_CYCLES  = 100000000,
  parameter int NUM_ALT      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_over,
  input  logic       hs_btn,
  input  logic [3:0] pA_score,
  input  logic [3:0] pB_score,
  output logic       scan_tick,
  output logic [3:0] highscore,
  output logic       highscore_disp,
  output logic       new_record
);

  localparam int SW     = $clog2(SCAN_DIV) + 1;
  localparam int PH_W   = $clog2(PHASE_CYCLES) + 1;
  localparam int PK_W   = $clog2(PEEK_CYCLES) + 1;
  localparam int TW     = (PH_W > PK_W) ? PH_W : PK_W;
  localparam int AW     = $clog2(NUM_ALT) + 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_PRE   = SW'(SCAN_DIV - 2);
  localparam logic [TW-1:0] PHASE_LAST = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] PEEK_LAST  = TW'(PEEK_CYCLES - 1);
  localparam logic [AW-1:0] ALT_LAST   = AW'(NUM_ALT - 1);

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    PEEK     = 2'd1,
    GO_SCORE = 2'd2,
    GO_HS    = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   scan_cnt;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   alt_cnt;
  logic            hs_btn_q;
  logic            btn_rise;
  logic [3:0]      game_max;

  function automatic logic [3:0] max3(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c);
    logic [3:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Press detection and the candidate highscore for a finishing game
  always_comb begin
    btn_rise = hs_btn & ~hs_btn_q;
    game_max = max3(highscore, pA_score, pB_score);
  end

  // Free-running scan divider; tick is registered so it coincides with the last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_cnt  <= scan_cnt + SW'(1);
      scan_tick <= (scan_cnt == SCAN_PRE);
    end
  end

  // Button edge register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_btn_q <= 1'b0;
    end else begin
      hs_btn_q <= hs_btn;
    end
  end

  // Display sequencer FSM with highscore bookkeeping; game_over overrides everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= PLAY;
      timer          <= '0;
      alt_cnt        <= '0;
      highscore      <= 4'd0;
      new_record     <= 1'b0;
      highscore_disp <= 1'b0;
    end else if (game_over) begin
      highscore      <= game_max;
      new_record     <= (game_max > highscore);
      state          <= GO_SCORE;
      timer          <= '0;
      alt_cnt        <= '0;
      highscore_disp <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          timer <= '0;
          if (btn_rise) begin
            state          <= PEEK;
            highscore_disp <= 1'b1;
          end else begin
            highscore_disp <= 1'b0;
          end
        end
        PEEK: begin
          if (btn_rise) begin
            timer <= '0;
          end else if (timer == PEEK_LAST) begin
            state          <= PLAY;
            timer          <= '0;
            new_record     <= 1'b0;
            highscore_disp <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GO_SCORE: begin
          if (timer == PHASE_LAST) begin
            state          <= GO_HS;
            timer          <= '0;
            highscore_disp <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GO_HS: begin
          if (timer == PHASE_LAST) begin
            timer          <= '0;
            alt_cnt        <= alt_cnt + AW'(1);
            highscore_disp <= 1'b0;
            if (alt_cnt == ALT_LAST) begin
              state      <= PLAY;
              new_record <= 1'b0;
            end else begin
              state <= GO_SCORE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state          <= PLAY;
          timer          <= '0;
          alt_cnt        <= '0;
          highscore_disp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: a countdown-based reference model predicts every cycle's outputs.
module tb_score_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int PHASE    = 5;
  localparam int PEEK     = 8;
  localparam int NALT     = 2;

  logic       clk;
  logic       rst;
  logic       game_over;
  logic       hs_btn;
  logic [3:0] pa;
  logic [3:0] pb;
  logic       scan_tick;
  logic [3:0] highscore;
  logic       highscore_disp;
  logic       new_record;

  score_display_ctrl #(
    .SCAN_DIV(SCAN_DIV), .PHASE_CYCLES(PHASE), .PEEK_CYCLES(PEEK), .NUM_ALT(NALT)
  ) dut (
    .clk(clk), .rst(rst), .game_over(game_over), .hs_btn(hs_btn),
    .pA_score(pa), .pB_score(pb), .scan_tick(scan_tick), .highscore(highscore),
    .highscore_disp(highscore_disp), .new_record(new_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tick;
    int disp;
    int hs;
    int nr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: mode 0 play, 1 peek, 2 scores phase, 3 highscore phase
  int m_scan, m_hs, m_nr, m_mode, m_left, m_pairs, m_btnq;

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.tick = (m_scan == SCAN_DIV - 1) ? 1 : 0;
    e.disp = (m_mode == 1 || m_mode == 3) ? 1 : 0;
    e.hs   = m_hs;
    e.nr   = m_nr;
    return e;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_hs = 0; m_nr = 0; m_mode = 0; m_left = 0; m_pairs = 0; m_btnq = 0;
  endtask

  task automatic model_edge(input int go, input int btn, input int a, input int b);
    int rise;
    int mx;
    rise    = (btn == 1 && m_btnq == 0) ? 1 : 0;
    m_btnq  = btn;
    m_scan  = (m_scan + 1) % SCAN_DIV;
    if (go == 1) begin
      mx = m_hs;
      if (a > mx) mx = a;
      if (b > mx) mx = b;
      m_nr    = (mx > m_hs) ? 1 : 0;
      m_hs    = mx;
      m_mode  = 2;
      m_left  = PHASE;
      m_pairs = NALT;
    end else if (m_mode == 0) begin
      if (rise == 1) begin
        m_mode = 1;
        m_left = PEEK;
      end
    end else if (m_mode == 1) begin
      if (rise == 1) m_left = PEEK;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_nr   = 0;
        end
      end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 3;
        m_left = PHASE;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_pairs--;
        if (m_pairs == 0) begin
          m_mode = 0;
          m_nr   = 0;
        end else begin
          m_mode = 2;
          m_left = PHASE;
        end
      end
    end
  endtask

  // starts and ends at a falling edge: compare this cycle, drive, predict next
  task automatic step(input int go, input int btn, input int a, input int b);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("scan_tick", int'(scan_tick), e.tick);
      check("hs_disp", int'(highscore_disp), e.disp);
      check("highscore", int'(highscore), e.hs);
      check("new_record", int'(new_record), e.nr);
    end
    game_over = go[0];
    hs_btn    = btn[0];
    pa        = a[3:0];
    pb        = b[3:0];
    model_edge(go, btn, a, b);
    sb.push_back(model_expect());
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input int btn);
    for (int i = 0; i < n; i++) step(0, btn, 0, 0);
  endtask

  // asynchronous reset asserted mid-cycle, released at the next falling edge
  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_tick", int'(scan_tick), 0);
    check("rst_disp", int'(highscore_disp), 0);
    check("rst_hs", int'(highscore), 0);
    check("rst_nr", int'(new_record), 0);
    game_over = 1'b0;
    hs_btn    = 1'b0;
    model_reset();
    sb.delete();
    sb.push_back(model_expect());
    @(negedge clk);
    rst = 1'b1;
    cyc = 1;
  endtask

  initial begin
    rst = 1'b1; game_over = 1'b0; hs_btn = 1'b0; pa = 4'd0; pb = 4'd0;
    #1 rst = 1'b0;
    @(negedge clk);
    apply_reset();

    // 1: idle, scan ticks only
    idle(20, 0);

    // 2: held button gives one peek; release and re-press restarts the peek
    idle(30, 1);
    idle(2, 0);
    idle(3, 1);
    idle(2, 0);
    step(0, 1, 0, 0);
    idle(12, 0);

    // 3: new record
    step(1, 0, 7, 3);
    idle(25, 0);

    // 4: no record, alternation still runs
    step(1, 0, 5, 6);
    idle(25, 0);

    // 5: game_over beats a simultaneous press; restart from the highscore phase
    step(0, 0, 0, 0);
    step(1, 1, 4, 2);
    idle(7, 1);
    step(1, 1, 2, 9);
    idle(8, 1);

    // 6: reset during the highscore phase
    apply_reset();
    idle(12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
